// File: rtl/aidan_mcnay_prime_div_ctrl_if.sv
// Handshake bundle for the trial-division controller: candidate stream,
// divider request/quotient streams and verdict stream.
interface aidan_mcnay_prime_div_ctrl_if #(
    parameter int unsigned nbits = 16
);
    logic [nbits-1:0] candidate;
    logic             req_val;
    logic             req_rdy;
    logic [nbits-1:0] div_opa;
    logic [nbits-1:0] div_opb;
    logic             div_istream_val;
    logic             div_istream_rdy;
    logic [nbits-1:0] div_result;
    logic             div_ostream_val;
    logic             div_ostream_rdy;
    logic             is_prime;
    logic [nbits-1:0] factor;
    logic             resp_val;
    logic             resp_rdy;

    modport master (
        input  candidate, req_val, div_istream_rdy, div_result,
               div_ostream_val, resp_rdy,
        output req_rdy, div_opa, div_opb, div_istream_val,
               div_ostream_rdy, is_prime, factor, resp_val
    );

    modport slave (
        output candidate, req_val, div_istream_rdy, div_result,
               div_ostream_val, resp_rdy,
        input  req_rdy, div_opa, div_opb, div_istream_val,
               div_ostream_rdy, is_prime, factor, resp_val
    );
endinterface

// File: rtl/aidan_mcnay_prime_div_ctrl.sv
// Trial-division primality controller: divides the latched candidate by
// d = 2, 3, ... through an external iterative divider and reports the verdict.
module aidan_mcnay_prime_div_ctrl #(
    parameter int unsigned nbits = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    aidan_mcnay_prime_div_ctrl_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         r_state;
    logic [nbits-1:0]   r_n;
    logic [nbits-1:0]   r_d;
    logic               r_is_prime;
    logic [nbits-1:0]   r_factor;

    logic [2*nbits-1:0] w_prod;
    logic               w_hit;
    logic               w_exhausted;
    logic               w_small;

    // Full-width product so q*d never aliases onto N through truncation.
    assign w_prod      = {{nbits{1'b0}}, bus.div_result} * {{nbits{1'b0}}, r_d};
    assign w_hit       = (w_prod == {{nbits{1'b0}}, r_n});
    assign w_exhausted = (bus.div_result <= r_d);
    assign w_small     = (bus.candidate[nbits-1:2] == '0);

    assign bus.req_rdy         = (r_state == IDLE);
    assign bus.div_istream_val = (r_state == SEND);
    assign bus.div_ostream_rdy = (r_state == WAIT);
    assign bus.resp_val        = (r_state == DONE);
    assign bus.div_opa         = r_n;
    assign bus.div_opb         = r_d;
    assign bus.is_prime        = r_is_prime;
    assign bus.factor          = r_factor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_d        <= '0;
            r_is_prime <= 1'b0;
            r_factor   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_val) begin
                        r_n <= bus.candidate;
                        r_d <= nbits'(2);
                        if (w_small) begin
                            // 2 and 3 are prime; 0 and 1 report themselves as the factor
                            r_state    <= DONE;
                            r_is_prime <= bus.candidate[1];
                            r_factor   <= bus.candidate[1] ? '0 : bus.candidate;
                        end else begin
                            r_state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.div_istream_rdy) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.div_ostream_val) begin
                        if (w_hit) begin
                            r_state    <= DONE;
                            r_is_prime <= 1'b0;
                            r_factor   <= r_d;
                        end else if (w_exhausted) begin
                            r_state    <= DONE;
                            r_is_prime <= 1'b1;
                            r_factor   <= '0;
                        end else begin
                            r_d     <= r_d + nbits'(1);
                            r_state <= SEND;
                        end
                    end
                end
                DONE: begin
                    if (bus.resp_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aidan_mcnay_prime_div_ctrl.sv
// Self-checking bench: plays divider and verdict consumer, compares every cycle
// against a trial-division model, plus literal verdicts for directed candidates.
module tb_aidan_mcnay_prime_div_ctrl;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aidan_mcnay_prime_div_ctrl_if #(.nbits(16)) bus();

    aidan_mcnay_prime_div_ctrl #(.nbits(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Spec rule in arithmetic form: stop on d | n, else stop prime once floor(n/d) <= d,
    // i.e. n < d*(d+1). Returns verdict, factor and number of divide requests.
    function automatic void model(input int unsigned n, output bit p,
                                  output int unsigned f, output int unsigned r);
        p = 1'b0;
        f = 0;
        r = 0;
        if (n < 4) begin
            p = (n == 2 || n == 3);
            f = (n < 2) ? n : 0;
            return;
        end
        for (int unsigned d = 2; d <= 300; d++) begin
            r++;
            if (n % d == 0) begin
                f = d;
                return;
            end
            if (n < d * (d + 1)) begin
                p = 1'b1;
                return;
            end
        end
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_req_rdy"},  32'(bus.req_rdy), 1);
        chk({tag, "_ival"},     32'(bus.div_istream_val), 0);
        chk({tag, "_ordy"},     32'(bus.div_ostream_rdy), 0);
        chk({tag, "_resp_val"}, 32'(bus.resp_val), 0);
        chk({tag, "_opa"},      32'(bus.div_opa), 0);
        chk({tag, "_opb"},      32'(bus.div_opb), 0);
        chk({tag, "_prime"},    32'(bus.is_prime), 0);
        chk({tag, "_factor"},   32'(bus.factor), 0);
    endtask

    task automatic run_cand(input logic [15:0] n, input bit stalls, output bit got_p,
                            output int unsigned got_f, output int unsigned got_reqs);
        bit          e_p;
        int unsigned e_f, e_reqs;
        int unsigned sent, cyc, lat, cur_d;
        bit          pend, done, p_stall_i, p_stall_r, p_prime;
        logic [15:0] p_opa, p_opb, p_fac;
        model(32'(n), e_p, e_f, e_reqs);
        got_p = 1'b0;
        got_f = 0;
        got_reqs = 0;
        chk("req_rdy_idle", 32'(bus.req_rdy), 1);
        bus.candidate = n;
        bus.req_val   = 1'b1;
        @(negedge clk);
        sent = 0; cyc = 0; lat = 0; cur_d = 0;
        pend = 1'b0; done = 1'b0; p_stall_i = 1'b0; p_stall_r = 1'b0;
        p_prime = 1'b0; p_opa = '0; p_opb = '0; p_fac = '0;
        while (!done && cyc < 5000) begin
            cyc++;
            // Keep offering garbage candidates: none may be taken outside IDLE.
            bus.req_val   = 1'b1;
            bus.candidate = 16'($urandom);
            chk("req_rdy_busy", 32'(bus.req_rdy), 0);
            chk("istream_val", 32'(bus.div_istream_val), 32'(!pend && sent < e_reqs));
            chk("ostream_rdy", 32'(bus.div_ostream_rdy), 32'(pend));
            chk("resp_val", 32'(bus.resp_val), 32'(!pend && sent == e_reqs));
            if (p_stall_i) begin
                chk("opa_stable", 32'(bus.div_opa), 32'(p_opa));
                chk("opb_stable", 32'(bus.div_opb), 32'(p_opb));
            end
            if (p_stall_r) begin
                chk("prime_stable", 32'(bus.is_prime), 32'(p_prime));
                chk("factor_stable", 32'(bus.factor), 32'(p_fac));
            end
            p_stall_i = 1'b0;
            p_stall_r = 1'b0;

            bus.div_ostream_val = 1'b0;
            bus.div_result      = 16'($urandom);
            if (pend) begin
                if (lat != 0) begin
                    lat--;
                end else begin
                    bus.div_ostream_val = 1'b1;
                    bus.div_result      = 16'(32'(n) / cur_d);
                    if (bus.div_ostream_rdy) pend = 1'b0;
                end
            end else if (stalls && $urandom_range(0, 3) == 0) begin
                bus.div_ostream_val = 1'b1;
            end

            bus.div_istream_rdy = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.div_istream_val) begin
                chk("opa", 32'(bus.div_opa), 32'(n));
                chk("opb", 32'(bus.div_opb), sent + 2);
                if (bus.div_istream_rdy) begin
                    cur_d = sent + 2;
                    sent++;
                    pend = 1'b1;
                    lat = stalls ? $urandom_range(0, 2) : 0;
                end else begin
                    p_stall_i = 1'b1;
                    p_opa = bus.div_opa;
                    p_opb = bus.div_opb;
                end
            end

            bus.resp_rdy = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.resp_val) begin
                chk("is_prime", 32'(bus.is_prime), 32'(e_p));
                chk("factor", 32'(bus.factor), e_f);
                got_p = bus.is_prime;
                got_f = 32'(bus.factor);
                got_reqs = sent;
                if (bus.resp_rdy) begin
                    done = 1'b1;
                end else begin
                    p_stall_r = 1'b1;
                    p_prime = bus.is_prime;
                    p_fac = bus.factor;
                end
            end
            @(negedge clk);
        end
        chk("verdict_in_budget", 32'(done), 1);
        bus.req_val = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.div_istream_rdy = 1'b0;
        bus.div_ostream_val = 1'b0;
        chk("req_rdy_after", 32'(bus.req_rdy), 1);
        chk("resp_val_after", 32'(bus.resp_val), 0);
    endtask

    task automatic directed(input logic [15:0] n, input bit ep, input int unsigned ef,
                            input int unsigned er, input bit stalls);
        bit          gp, mp;
        int unsigned gf, gr, mf, mr;
        model(32'(n), mp, mf, mr);
        chk("model_prime", 32'(mp), 32'(ep));
        chk("model_factor", mf, ef);
        chk("model_reqs", mr, er);
        run_cand(n, stalls, gp, gf, gr);
        chk("lit_prime", 32'(gp), 32'(ep));
        chk("lit_factor", gf, ef);
        chk("lit_reqs", gr, er);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gp;
        int unsigned gf, gr;
        reset = 1'b1;
        bus.candidate = '0;
        bus.req_val = 1'b0;
        bus.div_istream_rdy = 1'b0;
        bus.div_result = '0;
        bus.div_ostream_val = 1'b0;
        bus.resp_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        @(negedge clk);

        directed(16'd0,     1'b0, 0,  0,   1'b0);
        directed(16'd1,     1'b0, 1,  0,   1'b0);
        directed(16'd2,     1'b1, 0,  0,   1'b0);
        directed(16'd3,     1'b1, 0,  0,   1'b0);
        directed(16'd4,     1'b0, 2,  1,   1'b0);
        directed(16'd5,     1'b1, 0,  1,   1'b0);
        directed(16'd7,     1'b1, 0,  2,   1'b0);
        directed(16'd9,     1'b0, 3,  2,   1'b0);
        directed(16'd65535, 1'b0, 3,  2,   1'b0);
        directed(16'd65521, 1'b1, 0,  255, 1'b0);
        directed(16'd221,   1'b0, 13, 12,  1'b1);

        // Abort a candidate while its first quotient is outstanding.
        bus.candidate = 16'd221;
        bus.req_val = 1'b1;
        @(negedge clk);
        bus.req_val = 1'b0;
        bus.div_istream_rdy = 1'b1;
        chk("abort_ival", 32'(bus.div_istream_val), 1);
        @(negedge clk);
        bus.div_istream_rdy = 1'b0;
        chk("abort_wait", 32'(bus.div_ostream_rdy), 1);
        #2 reset = 1'b1;
        #1 chk_reset("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset("postrst");
        run_cand(16'd221, 1'b0, gp, gf, gr);
        chk("rerun_prime", 32'(gp), 0);
        chk("rerun_factor", gf, 13);

        for (int i = 0; i < 200; i++) begin
            run_cand(16'($urandom), 1'b1, gp, gf, gr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
